fifo_bank4: RTL and testbench

FIFO_BANK4 -- requirements
Module: fifo_bank4

---
 rtl/fifo_bank4_pkg.sv | 10 +
 rtl/fifo_core.sv | 45 ++++
 rtl/fifo_bank4.sv | 60 ++++++
 tb/tb_fifo_bank4.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fifo_bank4_pkg.sv
// fifo_bank4_pkg: shared defaults, bank size and pointer-width helper for the fifo bank
package fifo_bank4_pkg;
  localparam int DATA_W_DEF = 6;
  localparam int DEPTH_DEF = 4;
  localparam int N_FIFO = 4;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);
endpackage

// File: rtl/fifo_core.sv
// fifo_core: single circular fifo (clk, active-low sync reset, push/pop, din, comb dout at read pointer, empty/full)
module fifo_core
  import fifo_bank4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int PW = ptr_w(DEPTH);
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0] count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    empty = count_q == '0;
    full = count_q == (PW+1)'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
    count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  assign dout = mem_q[rptr_q];
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (reset && do_push) mem_q[wptr_q] <= din;
endmodule

// File: rtl/fifo_bank4.sv
// fifo_bank4: four fifos with id-steered push/pop, registered pop output and sticky overflow/underflow flags
module fifo_bank4
  import fifo_bank4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [1:0]        push_id,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  input  logic [1:0]        pop_id,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [N_FIFO-1:0] empty,
  output logic [N_FIFO-1:0] full,
  output logic [1:0]        error
);
  logic [N_FIFO-1:0] push_v, pop_v;
  logic [DATA_W-1:0] dout [N_FIFO];
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic data_valid_q, data_valid_d;
  logic [1:0] error_q, error_d;
  for (genvar i = 0; i < N_FIFO; i++) begin : g_fifo
    assign push_v[i] = push && push_id == 2'(i);
    assign pop_v[i] = valid && pop_id == 2'(i);
    fifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_core (
      .clk   (clk),
      .reset (reset),
      .push  (push_v[i]),
      .pop   (pop_v[i]),
      .din   (data_in),
      .dout  (dout[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end
  always_comb begin
    data_valid_d = valid && !empty[pop_id];
    data_out_d = data_valid_d ? dout[pop_id] : data_out_q;
    error_d = error_q | {valid && empty[pop_id],
                         push && full[push_id] && !(valid && pop_id == push_id)};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_q <= '0;
      data_valid_q <= 1'b0;
      error_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      data_valid_q <= data_valid_d;
      error_q <= error_d;
    end
  end
  assign data_out = data_out_q;
  assign data_valid = data_valid_q;
  assign error = error_q;
endmodule

// File: tb/tb_fifo_bank4.sv
// tb_fifo_bank4: queue-model scoreboard bench with directed scenarios and random traffic
module tb_fifo_bank4;
  localparam int DW = 6;
  localparam int DP = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic push = 1'b0;
  logic valid = 1'b0;
  logic [1:0] push_id = '0;
  logic [1:0] pop_id = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic data_valid;
  logic [3:0] empty, full;
  logic [1:0] error;
  int n_chk = 0;
  int n_fail = 0;
  int mq [4][$];
  int exp_q [$];
  logic [1:0] err_m = '0;
  int last_out = 0;
  logic rst_s;
  always #5 clk = ~clk;
  fifo_bank4 #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_id    (push_id),
    .data_in    (data_in),
    .valid      (valid),
    .pop_id     (pop_id),
    .data_out   (data_out),
    .data_valid (data_valid),
    .empty      (empty),
    .full       (full),
    .error      (error)
  );
  function automatic void check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction
  function automatic void check_flags();
    logic [3:0] e, f;
    for (int i = 0; i < 4; i++) begin
      e[i] = mq[i].size() == 0;
      f[i] = mq[i].size() == DP;
    end
    check("empty", int'(empty), int'(e));
    check("full", int'(full), int'(f));
    check("error", int'(error), int'(err_m));
  endfunction
  task automatic step(input logic p, input logic [1:0] pid, input int d,
                      input logic v, input logic [1:0] qid);
    bit pop_ok;
    @(negedge clk);
    push = p;
    push_id = pid;
    data_in = DW'(d);
    valid = v;
    pop_id = qid;
    pop_ok = v && mq[qid].size() > 0;
    if (pop_ok) exp_q.push_back(mq[qid].pop_front());
    if (v && !pop_ok) err_m[1] = 1'b1;
    if (p && mq[pid].size() < DP) mq[pid].push_back(int'(data_in));
    else if (p) err_m[0] = 1'b1;
    @(posedge clk);
    #1;
    check_flags();
  endtask
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset = 1'b0;
      push = 1'($urandom);
      valid = 1'($urandom);
      push_id = 2'($urandom);
      pop_id = 2'($urandom);
      data_in = DW'($urandom);
      for (int i = 0; i < 4; i++) mq[i].delete();
      err_m = '0;
      @(posedge clk);
      #1;
      check("rst_empty", int'(empty), 15);
      check("rst_full", int'(full), 0);
      check("rst_error", int'(error), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    push = 1'b0;
    valid = 1'b0;
  endtask
  task automatic idle();
    step(1'b0, 2'd0, 0, 1'b0, 2'd0);
  endtask
  always @(posedge clk) begin
    rst_s = reset;
    #1;
    if (!rst_s) begin
      check("rst_dv", int'(data_valid), 0);
      check("rst_dout", int'(data_out), 0);
      last_out = 0;
    end else if (data_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_dv: got data_valid=1 data_out=%0d expected data_valid=0 at %0t",
                 data_out, $time);
      end else begin
        last_out = exp_q.pop_front();
        check("data_out", int'(data_out), last_out);
        check("latency", exp_q.size(), 0);
      end
    end else begin
      check("missed_dv", exp_q.size(), 0);
      check("hold", int'(data_out), last_out);
    end
  end
  initial begin
    do_reset(2);
    idle();
    for (int i = 1; i <= 4; i++) step(1'b1, 2'd2, i, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 0, 1'b1, 2'd2);
    idle();
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 20 + i, 1'b0, 2'd0);
    step(1'b1, 2'd0, 9, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 0, 1'b1, 2'd0);
    idle();
    do_reset(1);
    step(1'b0, 2'd0, 0, 1'b1, 2'd3);
    step(1'b1, 2'd3, 5, 1'b1, 2'd3);
    step(1'b0, 2'd0, 0, 1'b1, 2'd3);
    idle();
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 10 + i, 1'b0, 2'd0);
    step(1'b1, 2'd1, 7, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 0, 1'b1, 2'd1);
    idle();
    do_reset(1);
    step(1'b1, 2'd0, 30, 1'b0, 2'd0);
    step(1'b1, 2'd1, 31, 1'b0, 2'd0);
    step(1'b1, 2'd1, 32, 1'b0, 2'd0);
    step(1'b1, 2'd2, 33, 1'b0, 2'd0);
    step(1'b1, 2'd3, 34, 1'b0, 2'd0);
    step(1'b1, 2'd3, 35, 1'b0, 2'd0);
    step(1'b0, 2'd0, 0, 1'b1, 2'd0);
    step(1'b0, 2'd0, 0, 1'b1, 2'd1);
    step(1'b0, 2'd0, 0, 1'b1, 2'd2);
    step(1'b0, 2'd0, 0, 1'b1, 2'd3);
    step(1'b0, 2'd0, 0, 1'b1, 2'd1);
    step(1'b0, 2'd0, 0, 1'b1, 2'd3);
    idle();
    do_reset(1);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) < 2) do_reset(1);
      else step(1'($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
                1'($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)));
    end
    idle();
    idle();
    check("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
